inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/pc_gen.sv | 26 ++
 rtl/inst_fetch.sv | 111 +++++++++++
 tb/tb_inst_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and types.
package riscv_pkg;

  localparam int PC_W    = 8;   // program-counter / byte-address width
  localparam int INSTR_W = 32;  // instruction word width
  localparam int PC_INC  = 4;   // sequential fetch step in bytes

  // Fetch control states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;

  // Next-PC source select
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INCR  = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  // A redirect target must be word aligned
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Next-PC mux (hold / +4 / redirect) and redirect alignment check.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int PC_W = riscv_pkg::PC_W
) (
  input  logic [PC_W-1:0] pc_i,
  input  pc_sel_e         sel_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_next_o,
  output logic            misaligned_o
);

  // Increment wraps naturally at PC_W bits; no overflow flag is wanted
  always_comb begin
    pc_next_o = pc_i;
    unique case (sel_i)
      PC_INCR:  pc_next_o = pc_i + PC_W'(PC_INC);
      PC_REDIR: pc_next_o = target_i;
      default:  pc_next_o = pc_i;
    endcase
  end

  assign misaligned_o = is_misaligned(target_i[1:0]);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, one-entry output beat register toward
// decode, redirect/flush handling, sticky misalignment fault, beat counter.
module inst_fetch
  import riscv_pkg::*;
#(
  parameter int            PC_W     = riscv_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               misalign_err,
  output logic [15:0]        fetch_count
);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               out_valid_q;
  logic [INSTR_W-1:0] out_instr_q;
  logic [PC_W-1:0]    out_pc_q;
  logic               err_q;
  logic [15:0]        cnt_q;

  logic    misaligned;
  logic    redir_ok, redir_bad;
  logic    accept, load;
  pc_sel_e pc_sel;

  // Redirects are ignored once faulted; only reset leaves FAULT
  assign redir_ok  = redirect_valid && !misaligned && (state_q != S_FAULT);
  assign redir_bad = redirect_valid &&  misaligned && (state_q != S_FAULT);
  assign accept    = out_valid_q && out_ready;
  // A redirect always wins over loading a new beat in the same cycle
  assign load      = (state_q == S_RUN) && !redirect_valid &&
                     (!out_valid_q || out_ready);

  // Select the next-PC source
  always_comb begin
    pc_sel = PC_HOLD;
    if (redir_ok)  pc_sel = PC_REDIR;
    else if (load) pc_sel = PC_INCR;
  end

  pc_gen #(.PC_W(PC_W)) u_pc_gen (
    .pc_i         (pc_q),
    .sel_i        (pc_sel),
    .target_i     (redirect_target),
    .pc_next_o    (pc_d),
    .misaligned_o (misaligned)
  );

  // Fetch FSM with registered beat, fault flag and counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      pc_q <= pc_d;
      // A beat taken by decode counts even if a redirect flushes this cycle
      if (accept && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      unique case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          if (redir_bad) begin
            err_q   <= 1'b1;
            state_q <= S_FAULT;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (redir_bad) begin
            err_q       <= 1'b1;
            out_valid_q <= 1'b0;
            state_q     <= S_FAULT;
          end else if (redir_ok) begin
            out_valid_q <= 1'b0;
          end else if (load) begin
            out_valid_q <= 1'b1;
            out_instr_q <= imem_data;
            out_pc_q    <= pc_q;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_FAULT;
        end
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_pc       = out_pc_q;
  assign misalign_err = err_q;
  assign fetch_count  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational instruction memory.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        misalign_err;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:63];
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[7:2]];

  inst_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  // Control snapshot {valid, err, count, imem_addr}; full adds {out_pc, out_instr}
  logic [25:0] ctl;
  logic [65:0] full;
  assign ctl  = {out_valid, misalign_err, fetch_count, imem_addr};
  assign full = {ctl, out_pc, out_instr};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 8'h00;
    tick(); tick();
    vec_cnt++;
    if (full !== {1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 32'h0}) begin
      err_cnt++; $display("FAIL reset: got %h want %h", full, {1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 32'h0});
    end
  endtask

  task automatic test_basic();
    rst_n = 1'b1;
    tick();
    vec_cnt++;
    if (ctl !== {1'b0, 1'b0, 16'd0, 8'h00}) begin
      err_cnt++; $display("FAIL idle_cycle: got %h want %h", ctl, {1'b0, 1'b0, 16'd0, 8'h00});
    end
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd0, 8'h04, 8'h00, 32'h00007033}) begin
      err_cnt++; $display("FAIL beat0: got %h want %h", full, {1'b1, 1'b0, 16'd0, 8'h04, 8'h00, 32'h00007033});
    end
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd1, 8'h08, 8'h04, 32'h00100093}) begin
      err_cnt++; $display("FAIL beat1: got %h want %h", full, {1'b1, 1'b0, 16'd1, 8'h08, 8'h04, 32'h00100093});
    end
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd2, 8'h0C, 8'h08, 32'hC0DE0008}) begin
      err_cnt++; $display("FAIL beat2_cnt2: got %h want %h", full, {1'b1, 1'b0, 16'd2, 8'h0C, 8'h08, 32'hC0DE0008});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (full !== {1'b1, 1'b0, 16'd2, 8'h0C, 8'h08, 32'hC0DE0008}) begin
        err_cnt++; $display("FAIL stall%0d: got %h want %h", i, full, {1'b1, 1'b0, 16'd2, 8'h0C, 8'h08, 32'hC0DE0008});
      end
    end
    out_ready = 1'b1;
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd3, 8'h10, 8'h0C, 32'hC0DE000C}) begin
      err_cnt++; $display("FAIL stall_release: got %h want %h", full, {1'b1, 1'b0, 16'd3, 8'h10, 8'h0C, 32'hC0DE000C});
    end
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd4, 8'h14, 8'h10, 32'hC0DE0010}) begin
      err_cnt++; $display("FAIL beat10: got %h want %h", full, {1'b1, 1'b0, 16'd4, 8'h14, 8'h10, 32'hC0DE0010});
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'h48;
    tick();
    vec_cnt++;
    if (ctl !== {1'b0, 1'b0, 16'd4, 8'h48}) begin
      err_cnt++; $display("FAIL redir_flush: got %h want %h", ctl, {1'b0, 1'b0, 16'd4, 8'h48});
    end
    redirect_valid = 1'b0;
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd4, 8'h4C, 8'h48, 32'h03002603}) begin
      err_cnt++; $display("FAIL redir_beat: got %h want %h", full, {1'b1, 1'b0, 16'd4, 8'h4C, 8'h48, 32'h03002603});
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h20;
    tick();
    vec_cnt++;
    if (ctl !== {1'b0, 1'b0, 16'd5, 8'h20}) begin
      err_cnt++; $display("FAIL accept_redir: got %h want %h", ctl, {1'b0, 1'b0, 16'd5, 8'h20});
    end
    redirect_valid = 1'b0;
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd5, 8'h24, 8'h20, 32'hC0DE0020}) begin
      err_cnt++; $display("FAIL accept_redir_beat: got %h want %h", full, {1'b1, 1'b0, 16'd5, 8'h24, 8'h20, 32'hC0DE0020});
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 8'hFC;
    tick();
    vec_cnt++;
    if (ctl !== {1'b0, 1'b0, 16'd6, 8'hFC}) begin
      err_cnt++; $display("FAIL wrap_redir: got %h want %h", ctl, {1'b0, 1'b0, 16'd6, 8'hFC});
    end
    redirect_valid = 1'b0;
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd6, 8'h00, 8'hFC, 32'hC0DE00FC}) begin
      err_cnt++; $display("FAIL wrap_fc: got %h want %h", full, {1'b1, 1'b0, 16'd6, 8'h00, 8'hFC, 32'hC0DE00FC});
    end
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd7, 8'h04, 8'h00, 32'h00007033}) begin
      err_cnt++; $display("FAIL wrap_00: got %h want %h", full, {1'b1, 1'b0, 16'd7, 8'h04, 8'h00, 32'h00007033});
    end
  endtask

  task automatic test_misalign();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 8'h4A;
    tick();
    vec_cnt++;
    if (ctl !== {1'b0, 1'b1, 16'd7, 8'h04}) begin
      err_cnt++; $display("FAIL misalign: got %h want %h", ctl, {1'b0, 1'b1, 16'd7, 8'h04});
    end
    redirect_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++;
      if (ctl !== {1'b0, 1'b1, 16'd7, 8'h04}) begin
        err_cnt++; $display("FAIL fault_hold%0d: got %h want %h", i, ctl, {1'b0, 1'b1, 16'd7, 8'h04});
      end
    end
    redirect_valid = 1'b1; redirect_target = 8'h40;
    tick();
    vec_cnt++;
    if (ctl !== {1'b0, 1'b1, 16'd7, 8'h04}) begin
      err_cnt++; $display("FAIL fault_ignore_redir: got %h want %h", ctl, {1'b0, 1'b1, 16'd7, 8'h04});
    end
    redirect_valid = 1'b0; rst_n = 1'b0;
    tick();
    vec_cnt++;
    if (full !== {1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 32'h0}) begin
      err_cnt++; $display("FAIL fault_reset: got %h want %h", full, {1'b0, 1'b0, 16'd0, 8'h00, 8'h00, 32'h0});
    end
  endtask

  task automatic test_idle_redirect();
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h48;
    tick();
    vec_cnt++;
    if (ctl !== {1'b0, 1'b0, 16'd0, 8'h48}) begin
      err_cnt++; $display("FAIL idle_redir: got %h want %h", ctl, {1'b0, 1'b0, 16'd0, 8'h48});
    end
    redirect_valid = 1'b0;
    tick();
    vec_cnt++;
    if (full !== {1'b1, 1'b0, 16'd0, 8'h4C, 8'h48, 32'h03002603}) begin
      err_cnt++; $display("FAIL idle_redir_beat: got %h want %h", full, {1'b1, 1'b0, 16'd0, 8'h4C, 8'h48, 32'h03002603});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | 32'(i * 4);
    mem[0]  = 32'h00007033;
    mem[1]  = 32'h00100093;
    mem[18] = 32'h03002603;   // 0x48
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_idle_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
